// File: rtl/relogio_pkg.sv
// Shared types and default parameters for the digital-clock control slice.
package relogio_pkg;

   typedef enum logic [1:0] {
      MODO_RUN      = 2'd0,
      MODO_SET_MIN  = 2'd1,
      MODO_SET_HORA = 2'd2
   } modo_t;

   localparam int SEC_PER_MIN_DEF = 60;
   localparam int PRESCALE_DEF    = 50_000_000;

endpackage

// File: rtl/ctrl_borda.sv
// Button synchronizer plus rising-edge detector; all flops reset to 1 so a
// button held through reset must be released and pressed again to fire.
module ctrl_borda (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic evento
);

   logic sync1, sync2, prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         prev  <= 1'b1;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign evento = sync2 & ~prev;

endmodule

// File: rtl/ctrl_relogio.sv
// Mode/timebase controller: 1 s prescaler, seconds count, minute pulses and
// the RUN -> SET_MIN -> SET_HORA set-time state machine with field blinking.
module ctrl_relogio
   import relogio_pkg::*;
#(
   parameter int PRESCALE    = PRESCALE_DEF,
   parameter int SEC_PER_MIN = SEC_PER_MIN_DEF
) (
   input  logic       ctrl_clock,
   input  logic       ctrl_reset,
   input  logic       ctrl_btn_modo,
   input  logic       ctrl_btn_inc,
   output logic       ctrl_inc_minuto,
   output logic       ctrl_inc_hora,
   output logic       ctrl_carry_en,
   output logic       ctrl_apaga_min,
   output logic       ctrl_apaga_hora,
   output logic [1:0] ctrl_modo,
   output logic [5:0] ctrl_segundos
);

   localparam int             CW       = $clog2(PRESCALE);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0]  CNT_MEIO = CW'(PRESCALE / 2 - 1);
   localparam logic [5:0]     SEG_MAX  = 6'(SEC_PER_MIN - 1);

   modo_t         modo, modo_prox;
   logic          ev_modo, ev_inc;
   logic          mudou, tick;
   logic [CW-1:0] cnt;
   logic [5:0]    seg;
   logic          fase, inc_min, inc_hora;

   ctrl_borda u_borda_modo (
      .clk    (ctrl_clock),
      .reset  (ctrl_reset),
      .btn    (ctrl_btn_modo),
      .evento (ev_modo)
   );

   ctrl_borda u_borda_inc (
      .clk    (ctrl_clock),
      .reset  (ctrl_reset),
      .btn    (ctrl_btn_inc),
      .evento (ev_inc)
   );

   always_ff @(posedge ctrl_clock) begin
      if (ctrl_reset) modo <= MODO_RUN;
      else            modo <= modo_prox;
   end

   always_comb begin
      modo_prox = modo;
      case (modo)
         MODO_RUN:      if (ev_modo) modo_prox = MODO_SET_MIN;
         MODO_SET_MIN:  if (ev_modo) modo_prox = MODO_SET_HORA;
         MODO_SET_HORA: if (ev_modo) modo_prox = MODO_RUN;
         default:       modo_prox = MODO_RUN;
      endcase
   end

   // Any mode change (including illegal-state recovery) restarts the timebase.
   assign mudou = (modo_prox != modo);
   assign tick  = (cnt == CNT_MAX);

   always_ff @(posedge ctrl_clock) begin
      if (ctrl_reset) begin
         cnt      <= '0;
         seg      <= '0;
         fase     <= 1'b0;
         inc_min  <= 1'b0;
         inc_hora <= 1'b0;
      end else begin
         if (mudou || tick) cnt <= '0;
         else               cnt <= cnt + 1'b1;

         if (mudou || modo != MODO_RUN) seg <= '0;
         else if (tick)                 seg <= (seg == SEG_MAX) ? 6'd0 : seg + 6'd1;

         if (mudou)                          fase <= 1'b0;
         else if (tick || cnt == CNT_MEIO)   fase <= ~fase;

         // A simultaneous mode event swallows the increment.
         inc_min  <= (modo == MODO_RUN && tick && seg == SEG_MAX) ||
                     (modo == MODO_SET_MIN && ev_inc && !ev_modo);
         inc_hora <= (modo == MODO_SET_HORA && ev_inc && !ev_modo);
      end
   end

   assign ctrl_inc_minuto = inc_min;
   assign ctrl_inc_hora   = inc_hora;
   assign ctrl_carry_en   = (modo == MODO_RUN);
   assign ctrl_apaga_min  = fase & (modo == MODO_SET_MIN);
   assign ctrl_apaga_hora = fase & (modo == MODO_SET_HORA);
   assign ctrl_modo       = modo;
   assign ctrl_segundos   = seg;

endmodule
